// File: rtl/funct_generator_pkg.sv
// Shared types and constants for the function-generator sample path.
package funct_generator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } reader_state_t;

  // Smallest divider that still lets a pop/capture finish inside one period.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/funct_generator_period_counter.sv
// Free-running sample-period counter: 0..div_eff, wraps, ticks on the wrap edge.
// The divider is clamped to MIN_DIV and latched only while loading or on a wrap,
// so a div change lands on the next period boundary.
module funct_generator_period_counter
  import funct_generator_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [DIV_WIDTH-1:0] div_clamp;

  assign div_clamp = (div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div;
  assign tick      = !load && (cnt == div_eff);

  // Count while running; hold at zero and track the divider while loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_eff <= DIV_WIDTH'(MIN_DIV);
    end else if (clr || load || tick) begin
      cnt     <= '0;
      div_eff <= div_clamp;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/funct_generator_fifo_reader.sv
// Read side of the function-generator sample FIFO: one pop per sample period,
// registered sample hold for the output stage, update strobe and underrun count.
module funct_generator_fifo_reader
  import funct_generator_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    DIV_WIDTH      = 16,
  parameter int                    UNDERRUN_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clrh,
  input  logic                      enh,
  input  logic [DIV_WIDTH-1:0]      div,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
  output logic [DATA_WIDTH-1:0]     sample,
  output logic                      sample_valid,
  output logic                      underrun,
  output logic [UNDERRUN_WIDTH-1:0] underrun_cnt,
  output logic                      busy
);

  reader_state_t state, state_n;
  logic          tick;
  logic          cnt_load;
  logic          rd_set;
  logic          cap;
  logic          und_hit;

  assign cnt_load = (state == IDLE);
  assign busy     = (state != IDLE);

  funct_generator_period_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_period (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clrh),
    .load  (cnt_load),
    .div   (div),
    .tick  (tick)
  );

  // State register; clear forces IDLE ahead of anything the FSM wants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    state <= IDLE;
    else if (clrh) state <= IDLE;
    else           state <= state_n;
  end

  // Next state plus one-cycle action flags for the output registers.
  always_comb begin
    state_n = state;
    rd_set  = 1'b0;
    cap     = 1'b0;
    und_hit = 1'b0;
    case (state)
      IDLE: if (enh) state_n = RUN;
      RUN: begin
        if (!enh) begin
          state_n = IDLE;
        end else if (tick) begin
          if (!fifo_empty) begin
            state_n = READ;
            rd_set  = 1'b1;
          end else begin
            und_hit = 1'b1;
          end
        end
      end
      // A pop in flight always completes, even if enh has dropped.
      READ: state_n = CAPTURE;
      CAPTURE: begin
        cap     = 1'b1;
        state_n = enh ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pop pulse and capture strobe, both one cycle wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd_en   <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      fifo_rd_en   <= rd_set && !clrh;
      sample_valid <= cap && !clrh;
    end
  end

  // Sample hold register: clear wins, otherwise load on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sample <= RESET_VALUE;
    else if (clrh) sample <= RESET_VALUE;
    else if (cap)  sample <= fifo_rd_data;
  end

  // Sticky underrun flag and saturating count of empty ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (clrh) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (und_hit) begin
      underrun     <= 1'b1;
      if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_funct_generator_fifo_reader.sv
// Bench for the FIFO reader: a queue-backed FIFO drives the DUT, and a
// period/edge-count reference model predicts every output after every edge.
module tb_funct_generator_fifo_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clrh;
  logic        enh;
  logic [15:0] div;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic [31:0] sample;
  logic        sample_valid;
  logic        underrun;
  logic [7:0]  underrun_cnt;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // fq: the physical FIFO seen by the DUT; mq: the model's own copy of it.
  logic [31:0] fq[$];
  logic [31:0] mq[$];

  // Reference model: run flag, edges into the period, period length,
  // edges until a pending capture lands.
  bit          m_run;
  int          m_cnt, m_p, m_cd;
  logic [31:0] m_sample, m_word;
  bit          m_sv, m_rd, m_und;
  int          m_ucnt;

  always #5 clk = ~clk;

  funct_generator_fifo_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clrh         (clrh),
    .enh          (enh),
    .div          (div),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int period_of(input logic [15:0] d);
    return ((d < 16'd2) ? 2 : int'(d)) + 1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_p = 3; m_cd = 0;
    m_sample = '0; m_word = '0;
    m_sv = 0; m_rd = 0; m_und = 0; m_ucnt = 0;
  endtask

  // Predict the effect of the coming rising edge from the current inputs.
  task automatic model_edge();
    m_sv = 0;
    m_rd = 0;
    if (clrh) begin
      m_run = 0; m_cnt = 0; m_cd = 0;
      m_sample = '0; m_und = 0; m_ucnt = 0;
      return;
    end
    if (!m_run) begin
      if (enh) begin
        m_run = 1; m_cnt = 0; m_p = period_of(div);
      end
    end else if (m_cd > 0) begin
      m_cnt++;
      m_cd--;
      if (m_cd == 0) begin
        m_sample = m_word;
        m_sv     = 1;
        if (!enh) m_run = 0;
      end
    end else if (!enh) begin
      m_run = 0;
    end else begin
      m_cnt++;
      if (m_cnt == m_p) begin
        m_cnt = 0;
        m_p   = period_of(div);
        if (mq.size() > 0) begin
          m_word = mq.pop_front();
          m_rd   = 1;
          m_cd   = 2;
        end else begin
          m_und = 1;
          if (m_ucnt < 255) m_ucnt++;
        end
      end
    end
  endtask

  task automatic check_outs();
    chk("sample",       sample,       m_sample);
    chk("sample_valid", sample_valid, m_sv);
    chk("fifo_rd_en",   fifo_rd_en,   m_rd);
    chk("underrun",     underrun,     m_und);
    chk("underrun_cnt", underrun_cnt, m_ucnt[7:0]);
    chk("busy",         busy,         m_run);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      logic r;
      r = fifo_rd_en;
      model_edge();
      @(posedge clk);
      #1;
      if (r && fq.size() > 0) fifo_rd_data = fq.pop_front();
      fifo_empty = (fq.size() == 0);
      check_outs();
    end
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    mq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic flush_fifo();
    fq.delete();
    mq.delete();
    fifo_empty = 1'b1;
  endtask

  // Step until the model reaches the given capture countdown, bounded.
  task automatic step_until_cd(input int cd, input string tag);
    int n;
    n = 0;
    while (m_cd != cd && n < 60) begin
      step(1);
      n++;
    end
    chk(tag, 32'(m_cd == cd), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; clrh = 1'b0; enh = 1'b0; div = 16'd4;
    fifo_empty = 1'b1; fifo_rd_data = '0;
    model_reset();
    #12;
    check_outs();
    rst_n = 1'b1;

    // Three words at div=4: one pop every 5 cycles.
    push(32'h11); push(32'h22); push(32'h33);
    enh = 1'b1;
    step(18);
    chk("plan1_last_sample", sample, 32'h33);
    chk("plan1_no_underrun", underrun, 1'b0);
    enh = 1'b0;
    step(2);

    // div=0 and div=1 both clamp to a 3-cycle period.
    div = 16'd0;
    for (int i = 0; i < 4; i++) push($urandom);
    enh = 1'b1;
    step(14);
    div = 16'd1;
    for (int i = 0; i < 3; i++) push($urandom);
    step(12);
    enh = 1'b0;
    step(2);

    // Randomized traffic, divider changes and enable toggles.
    enh = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) push($urandom);
      if ($urandom_range(15) == 0) div = 16'($urandom_range(6));
      if ($urandom_range(31) == 0) enh = ~enh;
      step(1);
    end
    enh = 1'b0;
    step(8);
    clrh = 1'b1;
    step(1);
    clrh = 1'b0;
    flush_fifo();

    // Starved FIFO: 2 words then 300 empty periods, counter saturates.
    div = 16'd2;
    push(32'hCAFE_0001); push(32'hCAFE_0002);
    enh = 1'b1;
    step(3 * 300 + 6);
    chk("sat_underrun_cnt", underrun_cnt, 8'hFF);
    chk("sat_hold_sample",  sample, 32'hCAFE_0002);
    chk("sat_underrun",     underrun, 1'b1);

    // Clear during CAPTURE discards the popped word.
    clrh = 1'b1;
    step(1);
    clrh = 1'b0;
    div = 16'd3;
    push(32'hAB);
    step_until_cd(1, "reach_capture");
    clrh = 1'b1;
    step(1);
    clrh = 1'b0;
    chk("clr_sample",   sample, 32'h0);
    chk("clr_busy",     busy, 1'b0);
    chk("clr_underrun", underrun_cnt, 8'h0);
    enh = 1'b0;
    step(2);

    // Drop enh while in READ: capture still completes, then idle, no more pops.
    div = 16'd2;
    push(32'h5A5A); push(32'h6B6B);
    enh = 1'b1;
    step_until_cd(2, "reach_read");
    enh = 1'b0;
    step(10);
    chk("enh_drop_sample", sample, 32'h5A5A);
    chk("enh_drop_busy",   busy, 1'b0);
    chk("enh_drop_left",   32'(fq.size()), 32'd1);
    flush_fifo();

    // Divider change mid-period lands at the next boundary.
    div = 16'd4;
    for (int i = 0; i < 6; i++) push($urandom);
    enh = 1'b1;
    step(7);
    div = 16'd9;
    step(35);
    step_until_cd(0, "idle_read");

    // Asynchronous reset mid-period.
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    flush_fifo();
    check_outs();
    enh = 1'b0;
    #3;
    rst_n = 1'b1;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
